// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-source/timing-generator bundle; master = generator, slave = pixel source.
// test_mode exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
  parameter int CW = 2,
  parameter int HW = 11,
  parameter int VW = 10
);
  logic          ce;
`ifdef VGA_TEST_PATTERN_EN
  logic          test_mode;
`endif
  logic [CW-1:0] red_in, green_in, blue_in;
  logic [HW-1:0] req_x, h_count;
  logic [VW-1:0] req_y, v_count;
  logic          req_valid, h_sync, v_sync, de, frame_start, line_start;
  logic [CW-1:0] red_out, green_out, blue_out;
  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  test_mode,
`endif
    input  ce, red_in, green_in, blue_in,
    output req_x, req_y, req_valid, h_count, v_count, h_sync, v_sync, de,
    output red_out, green_out, blue_out, frame_start, line_start
  );
  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output test_mode,
`endif
    output ce, red_in, green_in, blue_in,
    input  req_x, req_y, req_valid, h_count, v_count, h_sync, v_sync, de,
    input  red_out, green_out, blue_out, frame_start, line_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster counters plus a one-cycle registered sync/de/colour stage.
// Optional VGA_TEST_PATTERN_EN adds test_mode, replacing source colour with eight vertical bars.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1,
  parameter int CW       = 2,
  parameter int HW       = 11,
  parameter int VW       = 10
) (
  input logic           clk,
  input logic           rst_n,
  vga_timing_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: porch and sync widths must be at least 1");
  end
  if (H_TOTAL > (1 << HW) || V_TOTAL > (1 << VW)) begin : g_bad_width
    $error("vga_timing_gen: raster totals do not fit the counter widths");
  end

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, ls_q, ls_d, fs_q, fs_d, vld;
  logic [CW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

  always_comb begin
    h_d  = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d  = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
    vld  = (h_q < H_ACT) && (v_q < V_ACT);
    hs_d = (h_q >= HS_BEG && h_q < HS_END) ? H_POL : ~H_POL;
    vs_d = (v_q >= VS_BEG && v_q < VS_END) ? V_POL : ~V_POL;
    ls_d = (h_q == '0);
    fs_d = (h_q == '0) && (v_q == '0);
  end

`ifdef VGA_TEST_PATTERN_EN
  // Bar index only matters inside the active area; blanking masks the rest.
  logic [2:0] bar;
  assign bar = 3'({h_q, 3'b000} / (HW+3)'(H_ACTIVE));
  assign r_d = !vld ? '0 : vga.test_mode ? {CW{bar[2]}} : vga.red_in;
  assign g_d = !vld ? '0 : vga.test_mode ? {CW{bar[1]}} : vga.green_in;
  assign b_d = !vld ? '0 : vga.test_mode ? {CW{bar[0]}} : vga.blue_in;
`else
  assign r_d = vld ? vga.red_in   : '0;
  assign g_d = vld ? vga.green_in : '0;
  assign b_d = vld ? vga.blue_in  : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else if (vga.ce) begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= vld;
      ls_q <= ls_d;
      fs_q <= fs_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign vga.h_count     = h_q;
  assign vga.v_count     = v_q;
  assign vga.req_x       = h_q;
  assign vga.req_y       = v_q;
  assign vga.req_valid   = vld;
  assign vga.h_sync      = hs_q;
  assign vga.v_sync      = vs_q;
  assign vga.de          = de_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;
  assign vga.red_out     = r_q;
  assign vga.green_out   = g_q;
  assign vga.blue_out    = b_q;
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator, the successor to the fixed 800x600 sync and colour logic inside the video card top.
- Produces h/v sync with selectable polarity, a data-enable signal, and pixel request coordinates.
- Registers an N-bit-per-channel RGB stream aligned to sync, with a one-cycle pixel-fetch latency.
- Sits between the pixel source (frame buffer or pattern logic) and the DAC/resistor-ladder pins.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (clocks)
- H_SYNC, 120, horizontal sync width
- H_BP, 64, horizontal back porch
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 23, vertical back porch
- H_POL, 1, 1 = h_sync active-high
- V_POL, 1, 1 = v_sync active-high
- CW, 2, bits per colour channel
- HW, 11, h counter width (must hold H_TOTAL-1)
- VW, 10, v counter width (must hold V_TOTAL-1)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  pixel clock enable; all state holds when low
- red_in/green_in/blue_in  in  CW each  pixel colour for the current request
- req_x  out  HW  requested pixel column (= h_count)
- req_y  out  VW  requested pixel row (= v_count)
- req_valid  out  1  request lies in the active area
- h_count  out  HW  raw horizontal counter
- v_count  out  VW  raw vertical counter
- h_sync  out  1  horizontal sync, aligned with colour outputs
- v_sync  out  1  vertical sync, aligned with colour outputs
- de  out  1  display enable, aligned with colour outputs
- red_out/green_out/blue_out  out  CW each  blanked registered colour
- frame_start  out  1  one-cycle pulse with pixel (0,0) at the output stage
- line_start  out  1  one-cycle pulse with column 0 at the output stage

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1040 by default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (666 by default).
- Reset, asynchronous, while rst_n is low:
  - h_count = 0, v_count = 0.
  - h_sync = ~H_POL, v_sync = ~V_POL.
  - de, colour outputs, frame_start and line_start all 0.
- Stage 0 (counters), on clk rising edge with ce = 1:
  - h_count increments and wraps from H_TOTAL-1 to 0.
  - On that wrap, v_count increments and wraps from V_TOTAL-1 to 0.
  - With ce = 0, every register holds, including the output stage.
- Request outputs are combinational from the counters:
  - req_x = h_count, req_y = v_count.
  - req_valid = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- Stage 1 (output), registered on the same ce-qualified edge:
  - de <= req_valid.
  - h_sync <= H_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, otherwise ~H_POL.
  - v_sync <= V_POL when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC, otherwise ~V_POL. v_sync changes on the line boundary, together with h_count = 0.
  - Colour outputs <= colour inputs when req_valid, else 0. Blanking is forced; source values outside the active area are ignored.
  - line_start <= (h_count == 0); frame_start <= (h_count == 0 && v_count == 0).
- Latency: colour inputs are sampled in the cycle their request is presented and appear 1 ce-cycle later. Sync and de carry the same 1-cycle lag, so the output group is mutually aligned.
- Boundary conditions:
  - Last pixel (H_TOTAL-1, V_TOTAL-1) is followed by (0,0); frame_start fires one cycle later.
  - ce deasserted mid-line freezes the raster exactly.
  - Reset mid-frame restarts at (0,0); the first frame_start pulse comes one ce-cycle after reset release.
- Elaboration error if any porch or sync parameter is < 1, or if a total exceeds its counter width.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input test_mode (1 bit).
  - While test_mode = 1, colour inputs are ignored and stage 1 drives eight vertical colour bars.
  - Bar index = (req_x * 8) / H_ACTIVE; each bit of the index drives one channel at full scale (all-ones) or zero: bit0 = blue, bit1 = green, bit2 = red.
  - Blanking and latency are unchanged.
- When undefined: no test_mode port and no pattern logic.

Test Plan:
- Reset, then release with ce = 1 and default parameters -> h_count 0..1039, v_count 0..665; frame_start period exactly 692640 clocks; line_start period 1040.
- Default timing, h_sync check -> h_sync high for 120 clocks each line, first asserting the cycle after h_count = 856; de high for 800 clocks per line on lines 0..599 only.
- Small set (H 8/2/3/1, V 4/1/2/1, H_POL = 0, V_POL = 0) -> H_TOTAL 14, V_TOTAL 8; h_sync low for 3 clocks after h_count = 10; v_sync low during lines 5..6; colour 3/3/3 driven only while de = 1, otherwise 0.
- ce toggled 1,0,0,1 mid-line -> counters and all outputs hold for the two low cycles, then resume without a skipped pixel.
- rst_n pulled low at pixel (400,300) -> outputs go to reset values immediately without waiting for clk; after release the raster restarts at (0,0).
- With VGA_TEST_PATTERN_EN and test_mode = 1 (defaults, CW = 2) -> red_out/green_out/blue_out: x = 0 gives 0/0/0, x = 100 gives 0/0/3, x = 799 gives 3/3/3; blanked outside the active area.
